// File: rtl/seq_match_checker_if.sv
// Handshake bundle between the button/timebase side and the sequence checker.
interface seq_match_checker_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic [15:0]      seed;
  logic [LEN_W-1:0] length;
  logic             btn_valid;
  logic [1:0]       btn_sym;
  logic             tick;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [LEN_W-1:0] count;

  modport master (
    output start, seed, length, btn_valid, btn_sym, tick,
    input  busy, done, pass, fail, fail_code, count
  );

  modport slave (
    input  start, seed, length, btn_valid, btn_sym, tick,
    output busy, done, pass, fail, fail_code, count
  );
endinterface

// File: rtl/seq_match_checker.sv
// Regenerates the memory-game LFSR symbol sequence and checks player entries
// against it, with a per-entry tick timeout.
module seq_match_checker #(
  parameter int TIMEOUT = 8,
  parameter int LEN_W   = 5
) (
  input logic           clock,
  input logic           reset,
  seq_match_checker_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, PASS, FAIL} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [TW-1:0]    timer;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_nx;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic [1:0]       code_q;

  // x^16+x^5+x^3+x^2+1, Galois form
  function automatic logic [15:0] step(input logic [15:0] q);
    logic f;
    f = q[15];
    return {q[14:5], q[4] ^ f, q[3], q[2] ^ f, q[1] ^ f, q[0], f};
  endfunction

  assign count_nx = count_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lfsr    <= 16'h0001;
      timer   <= TW'(TIMEOUT);
      count_q <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, PASS, FAIL: begin
          if (bus.start) begin
            lfsr    <= step((bus.seed == 16'h0000) ? 16'h0001 : bus.seed);
            count_q <= '0;
            len_q   <= bus.length;
            timer   <= TW'(TIMEOUT);
            fail_q  <= 1'b0;
            code_q  <= 2'b00;
            if (bus.length == '0) begin
              state  <= PASS;
              pass_q <= 1'b1;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state  <= WAIT;
              pass_q <= 1'b0;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          // A button entry takes priority over a coincident tick.
          if (bus.btn_valid) begin
            if (bus.btn_sym == lfsr[1:0]) begin
              count_q <= count_nx;
              if (count_nx == len_q) begin
                state  <= PASS;
                pass_q <= 1'b1;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                lfsr  <= step(lfsr);
                timer <= TW'(TIMEOUT);
              end
            end else begin
              state  <= FAIL;
              fail_q <= 1'b1;
              code_q <= 2'b01;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end else if (bus.tick) begin
            if (timer == TW'(1)) begin
              state  <= FAIL;
              fail_q <= 1'b1;
              code_q <= 2'b10;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = code_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_seq_match_checker.sv
// Self-checking bench for seq_match_checker: directed scenarios plus randomized
// rounds checked against a sequence/verdict reference model.
module tb_seq_match_checker;
  localparam int TIMEOUT = 8;
  localparam int LEN_W   = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  seq_match_checker_if #(.LEN_W(LEN_W)) bus ();

  seq_match_checker #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // {busy, done, pass, fail, fail_code, count}
  logic [10:0] obs;
  logic [10:0] e;
  assign obs = {bus.busy, bus.done, bus.pass, bus.fail, bus.fail_code, bus.count};

  function automatic logic [10:0] ev(bit b, bit d, bit p, bit f, logic [1:0] c, int n);
    return {b, d, p, f, c, 5'(n)};
  endfunction

  // Reference: next value is the left shift, xor'ed with tap mask 0x2D when the msb falls out.
  function automatic logic [15:0] ref_next(logic [15:0] q);
    return (q << 1) ^ (q[15] ? 16'h002D : 16'h0000);
  endfunction

  function automatic logic [1:0] ref_sym(logic [15:0] sd, int i);
    logic [15:0] q;
    q = (sd == 16'h0000) ? 16'h0001 : sd;
    for (int k = 0; k <= i; k++) q = ref_next(q);
    return q[1:0];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic start_round(logic [15:0] sd, int ln);
    bus.start  = 1'b1;
    bus.seed   = sd;
    bus.length = LEN_W'(ln);
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic press(logic [1:0] s);
    bus.btn_valid = 1'b1;
    bus.btn_sym   = s;
    cyc();
    bus.btn_valid = 1'b0;
    bus.tick      = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.seed = '0; bus.length = '0;
    bus.btn_valid = 0; bus.btn_sym = '0; bus.tick = 0;
    reset = 1'b1;
    cyc(); cyc();
    e = ev(0, 0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, e); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_pass_seq();
    start_round(16'h8000, 3);
    press(2'd1);
    e = ev(1, 0, 0, 0, 0, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL pass_seq_1 got=%h exp=%h", obs, e); end
    press(2'd2);
    e = ev(1, 0, 0, 0, 0, 2); checks++;
    if (obs !== e) begin failures++; $display("FAIL pass_seq_2 got=%h exp=%h", obs, e); end
    press(2'd0);
    e = ev(0, 1, 1, 0, 0, 3); checks++;
    if (obs !== e) begin failures++; $display("FAIL pass_seq_done got=%h exp=%h", obs, e); end
    cyc();
    e = ev(0, 0, 1, 0, 0, 3); checks++;
    if (obs !== e) begin failures++; $display("FAIL pass_seq_hold got=%h exp=%h", obs, e); end
  endtask

  task automatic test_mismatch();
    start_round(16'h8000, 3);
    press(2'd1);
    press(2'd3);
    e = ev(0, 1, 0, 1, 2'b01, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL mismatch got=%h exp=%h", obs, e); end
    bus.btn_valid = 1'b1; bus.tick = 1'b1;
    cyc();
    bus.btn_valid = 1'b0; bus.tick = 1'b0;
    e = ev(0, 0, 0, 1, 2'b01, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL mismatch_hold got=%h exp=%h", obs, e); end
  endtask

  task automatic test_zero_seed();
    start_round(16'h0000, 1);
    press(2'd2);
    e = ev(0, 1, 1, 0, 0, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL zero_seed got=%h exp=%h", obs, e); end
  endtask

  task automatic test_timeout();
    start_round(16'h0001, 2);
    for (int t = 0; t < TIMEOUT - 1; t++) tick_pulse();
    e = ev(1, 0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout_early got=%h exp=%h", obs, e); end
    tick_pulse();
    e = ev(0, 1, 0, 1, 2'b10, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout got=%h exp=%h", obs, e); end
    start_round(16'h0001, 2);
    for (int t = 0; t < TIMEOUT - 1; t++) tick_pulse();
    press(2'd2);
    for (int t = 0; t < TIMEOUT - 1; t++) tick_pulse();
    e = ev(1, 0, 0, 0, 0, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL timer_reload got=%h exp=%h", obs, e); end
    tick_pulse();
    e = ev(0, 1, 0, 1, 2'b10, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout_after_reload got=%h exp=%h", obs, e); end
  endtask

  task automatic test_same_cycle();
    start_round(16'h0001, 2);
    for (int t = 0; t < TIMEOUT - 1; t++) tick_pulse();
    bus.tick = 1'b1;
    press(2'd2);
    e = ev(1, 0, 0, 0, 0, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL btn_beats_tick got=%h exp=%h", obs, e); end
    start_round(16'h8000, 5);
    e = ev(1, 0, 0, 0, 0, 1); checks++;
    if (obs !== e) begin failures++; $display("FAIL start_in_wait got=%h exp=%h", obs, e); end
    press(ref_sym(16'h0001, 1));
    e = ev(0, 1, 1, 0, 0, 2); checks++;
    if (obs !== e) begin failures++; $display("FAIL start_in_wait_seq got=%h exp=%h", obs, e); end
  endtask

  task automatic test_reset_mid_wait();
    start_round(16'h8000, 3);
    press(2'd1);
    press(2'd2);
    #2 reset = 1'b1;
    #1;
    e = ev(0, 0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_mid_wait got=%h exp=%h", obs, e); end
    cyc();
    reset = 1'b0;
    cyc();
    e = ev(0, 0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_no_done got=%h exp=%h", obs, e); end
  endtask

  task automatic test_len_zero();
    start_round(16'h1234, 0);
    e = ev(0, 1, 1, 0, 0, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL len_zero got=%h exp=%h", obs, e); end
    cyc();
    e = ev(0, 0, 1, 0, 0, 0); checks++;
    if (obs !== e) begin failures++; $display("FAIL len_zero_hold got=%h exp=%h", obs, e); end
  endtask

  task automatic test_random();
    logic [15:0] sd;
    logic [1:0]  exp_s, s;
    int ln, k;
    bit over, wrong;
    for (int r = 0; r < 40; r++) begin
      sd = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      ln = $urandom_range(1, 6);
      start_round(sd, ln);
      e = ev(1, 0, 0, 0, 0, 0); checks++;
      if (obs !== e) begin failures++; $display("FAIL rnd_start r=%0d got=%h exp=%h", r, obs, e); end
      over = 1'b0;
      for (int i = 0; i < ln && !over; i++) begin
        k = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
        for (int t = 0; t < k; t++) begin
          if ($urandom_range(0, 1) == 1) cyc();
          tick_pulse();
        end
        if (k == TIMEOUT) begin
          e = ev(0, 1, 0, 1, 2'b10, i); checks++;
          if (obs !== e) begin failures++; $display("FAIL rnd_timeout r=%0d i=%0d got=%h exp=%h", r, i, obs, e); end
          over = 1'b1;
        end else begin
          exp_s = ref_sym(sd, i);
          wrong = ($urandom_range(0, 6) == 0);
          s = wrong ? (exp_s ^ 2'($urandom_range(1, 3))) : exp_s;
          bus.tick = ($urandom_range(0, 3) == 0);
          press(s);
          if (wrong) begin
            e = ev(0, 1, 0, 1, 2'b01, i);
            over = 1'b1;
          end else if (i + 1 == ln) begin
            e = ev(0, 1, 1, 0, 0, i + 1);
          end else begin
            e = ev(1, 0, 0, 0, 0, i + 1);
          end
          checks++;
          if (obs !== e) begin failures++; $display("FAIL rnd_press r=%0d i=%0d got=%h exp=%h", r, i, obs, e); end
        end
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_pass_seq();
    test_mismatch();
    test_zero_seed();
    test_timeout();
    test_same_cycle();
    test_reset_mid_wait();
    test_len_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_match_checker.md
Name: seq_match_checker

Overview:
Consumer end of the 16-bit Galois LFSR sequence source used by the memory game. It regenerates the game's symbol sequence from the same seed and polynomial, and compares each player button entry against the expected symbol. It also enforces a per-entry time limit. It reports pass, mismatch or timeout to the game controller and sits between the button debouncers and the game FSM.

Parameters:
TIMEOUT, 8, number of tick pulses allowed per entry before a timeout fail (must be >= 1)
LEN_W, 5, width of the length and count fields

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a check round; sampled only in IDLE, PASS or FAIL
seed  input  16  LFSR seed for the round, captured on start
length  input  LEN_W  number of symbols to match, captured on start
btn_valid  input  1  one-cycle strobe: player entered a symbol
btn_sym  input  2  entered symbol, valid with btn_valid
tick  input  1  one-cycle timebase strobe (e.g. 10 Hz)
busy  output  1  high in WAIT
done  output  1  one-cycle pulse on entry to PASS or FAIL
pass  output  1  held high in PASS
fail  output  1  held high in FAIL
fail_code  output  2  00 none, 01 mismatch, 10 timeout; held in FAIL
count  output  LEN_W  symbols matched so far in current round

Behaviour:
- Reset (async):
  - state IDLE.
  - lfsr = 16'h0001, timer = TIMEOUT.
  - All outputs 0.
  - Reset during WAIT abandons the round with no done pulse.
- LFSR step function:
  - Polynomial x^16+x^5+x^3+x^2+1, Galois form, feedback f = q[15].
  - n[0]=f, n[1]=q[0], n[2]=q[1]^f, n[3]=q[2]^f, n[4]=q[3], n[5]=q[4]^f, n[15:6]=q[14:5].
- Expected symbol is lfsr[1:0] of the current state. Symbol i is taken after i+1 steps from the seed.
- A seed of 16'h0000 is replaced by 16'h0001. This prevents lock-up.
- States: IDLE, WAIT, PASS, FAIL.
- IDLE/PASS/FAIL + start:
  - lfsr <= step(seed_eff), count <= 0, timer <= TIMEOUT.
  - pass, fail and fail_code are cleared.
  - If length == 0: go to PASS next cycle with a done pulse. Otherwise go to WAIT.
- WAIT + btn_valid, btn_sym == lfsr[1:0]:
  - count <= count+1.
  - If count+1 == length: go to PASS and pulse done.
  - Otherwise: lfsr <= step(lfsr), timer <= TIMEOUT.
- WAIT + btn_valid, btn_sym != lfsr[1:0]: go to FAIL with fail_code 01; count unchanged.
- WAIT + tick, no btn_valid:
  - If timer == 1: go to FAIL with fail_code 10.
  - Otherwise timer <= timer-1.
- Same-cycle btn_valid and tick: the button wins. The tick is ignored that cycle.
- Latency: the verdict is registered the cycle after the deciding btn_valid or tick. done is high for exactly that cycle.
- start while in WAIT is ignored.
- btn_valid and tick outside WAIT are ignored.
- PASS/FAIL hold their outputs until the next start or reset.
- count saturation is impossible: the round ends at count == length.

Test Plan:
- Seed 16'h8000, length 3; enter 1, 2, 0 on successive btn_valid (states 002D, 005A, 00B4) -> count goes 1,2; done pulse with pass=1, count=3, fail_code=00.
- Seed 16'h8000, length 3; enter 1, then 3 -> FAIL, fail_code=01, count=1, done one cycle.
- Seed 16'h0000, length 1; enter 2 -> PASS, which proves the 0→0001 substitution (step gives 0002).
- TIMEOUT=8, seed 16'h0001, length 2; no buttons, 8 tick pulses -> fail_code=10 on the cycle after the 8th tick. Seven ticks then a correct button (2) -> no fail, timer reloaded.
- btn_valid (correct) and tick in the same cycle with timer==1 -> match accepted, no timeout. Also: start asserted mid-WAIT -> ignored, count unchanged.
- Reset asserted mid-WAIT with count=2 -> outputs 0 immediately, no done. length 0 start -> pass=1 and done on next cycle.
